// File: rtl/ahb_slave_bridge_v2_if.sv
// Bus bundle for ahb_slave_bridge_v2: AHB-Lite slave side plus the valid/ready backend side.
// Member names follow the slave's point of view (i_* driven toward the slave, o_* driven by it).
interface ahb_slave_bridge_v2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    i_hselx;
    logic                    i_hready;
    logic [1:0]              i_htrans;
    logic [2:0]              i_hsize;
    logic                    i_hwrite;
    logic [ADDR_WIDTH-1:0]   i_haddr;
    logic [DATA_WIDTH-1:0]   i_hwdata;
    logic                    o_hreadyout;
    logic                    o_hresp;
    logic [DATA_WIDTH-1:0]   o_hrdata;
    logic                    o_valid;
    logic                    o_rd0_wr1;
    logic [ADDR_WIDTH-1:0]   o_addr;
    logic [DATA_WIDTH-1:0]   o_wr_data;
    logic [DATA_WIDTH/8-1:0] o_wstrb;
    logic                    i_ready;
    logic                    i_rd_valid;
    logic [DATA_WIDTH-1:0]   i_rd_data;
    logic                    i_rd_err;

    modport slave (
        input  i_hselx, i_hready, i_htrans, i_hsize, i_hwrite, i_haddr, i_hwdata,
        output o_hreadyout, o_hresp, o_hrdata,
        output o_valid, o_rd0_wr1, o_addr, o_wr_data, o_wstrb,
        input  i_ready, i_rd_valid, i_rd_data, i_rd_err
    );

    modport master (
        output i_hselx, i_hready, i_htrans, i_hsize, i_hwrite, i_haddr, i_hwdata,
        input  o_hreadyout, o_hresp, o_hrdata,
        input  o_valid, o_rd0_wr1, o_addr, o_wr_data, o_wstrb,
        output i_ready, i_rd_valid, i_rd_data, i_rd_err
    );
endinterface

// File: rtl/ahb_slave_bridge_v2.sv
// AHB-Lite slave bridging pipelined transfers onto a valid/ready backend request port.
// Optional backend wait timeout is compiled in with `define AHB_SLV_TIMEOUT_EN.
module ahb_slave_bridge_v2 #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPACE     = 'h1000,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input logic                   i_clk_ahb,
    input logic                   i_rst_ahb,
    ahb_slave_bridge_v2_if.slave  bus
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LOG = $clog2(STRB_W);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("ahb_slave_bridge_v2: DATA_WIDTH must be 32 or 64");
    end
    if ((ADDR_SPACE & (ADDR_SPACE - 1'b1)) != '0) begin : g_bad_space
        $error("ahb_slave_bridge_v2: ADDR_SPACE must be a power of two");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ahb_slave_bridge_v2: TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [2:0] {IDLE, WR_DATA, REQ, RD_RESP, ERR1, ERR2} state_t;
    state_t state, state_nxt;

    logic                  accept;
    logic                  addr_err;
    logic                  size_err;
    logic                  align_err;
    logic                  rd_capture;
    logic                  timeout;
    logic [ADDR_WIDTH:0]   addr_diff;

    function automatic logic [STRB_W-1:0] byte_strobe(input logic [2:0]          size,
                                                      input logic [BYTE_LOG-1:0] lsb);
        logic [STRB_W-1:0] strb;
        int lo;
        int hi;
        lo = int'(lsb);
        hi = lo + (1 << size);
        for (int i = 0; i < STRB_W; i++) begin
            strb[i] = (i >= lo) && (i < hi);
        end
        return strb;
    endfunction

    // Extra MSB on the difference flags addresses below the window without a signed compare.
    assign addr_diff = {1'b0, bus.i_haddr} - {1'b0, BASE_ADDR};
    assign size_err  = bus.i_hsize > 3'(BYTE_LOG);
    assign align_err = (bus.i_haddr[7:0] & ((8'd1 << bus.i_hsize) - 8'd1)) != 8'd0;
    assign addr_err  = addr_diff[ADDR_WIDTH] || (addr_diff[ADDR_WIDTH-1:0] >= ADDR_SPACE) ||
                       size_err || align_err;
    assign accept    = bus.i_hselx && bus.i_hready && bus.i_htrans[1];
    assign rd_capture = !bus.o_rd0_wr1 && bus.i_rd_valid &&
                        ((state == REQ && bus.i_ready) || state == RD_RESP);

`ifdef AHB_SLV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (state == REQ || state == RD_RESP) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake/response outputs are pure state decodes, so reset forces them immediately.
    always_comb begin
        state_nxt       = state;
        bus.o_hreadyout = 1'b0;
        bus.o_hresp     = 1'b0;
        bus.o_valid     = 1'b0;
        case (state)
            IDLE: begin
                bus.o_hreadyout = 1'b1;
                if (accept) begin
                    if (addr_err)          state_nxt = ERR1;
                    else if (bus.i_hwrite) state_nxt = WR_DATA;
                    else                   state_nxt = REQ;
                end
            end
            WR_DATA: state_nxt = REQ;
            REQ: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) begin
                    if (bus.o_rd0_wr1 || bus.i_rd_valid) state_nxt = bus.i_rd_err ? ERR2 : IDLE;
                    else                                 state_nxt = RD_RESP;
                end else if (timeout) begin
                    state_nxt = ERR1;
                end
            end
            RD_RESP: begin
                if (bus.i_rd_valid) state_nxt = bus.i_rd_err ? ERR2 : IDLE;
                else if (timeout)   state_nxt = ERR1;
            end
            ERR1: begin
                bus.o_hresp = 1'b1;
                state_nxt   = ERR2;
            end
            ERR2: begin
                bus.o_hreadyout = 1'b1;
                bus.o_hresp     = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request attributes are latched only at a clean accept and stay put while o_valid is high.
    always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
        if (i_rst_ahb) begin
            bus.o_addr    <= '0;
            bus.o_rd0_wr1 <= 1'b0;
            bus.o_wstrb   <= '0;
            bus.o_wr_data <= '0;
            bus.o_hrdata  <= '0;
        end else begin
            if (state == IDLE && accept && !addr_err) begin
                bus.o_addr    <= addr_diff[ADDR_WIDTH-1:0];
                bus.o_rd0_wr1 <= bus.i_hwrite;
                bus.o_wstrb   <= bus.i_hwrite ? byte_strobe(bus.i_hsize, bus.i_haddr[BYTE_LOG-1:0])
                                              : '1;
            end
            if (state == WR_DATA) begin
                bus.o_wr_data <= bus.i_hwdata;
            end
            if (rd_capture) begin
                bus.o_hrdata <= bus.i_rd_data;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_bridge_v2.sv
// Randomized bench for ahb_slave_bridge_v2: transaction-level reference model plus backend responder.
module tb_ahb_slave_bridge_v2;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] SPACE = 32'h0000_1000;
    localparam logic [1:0]  NS   = 2'b10;
    localparam logic [1:0]  SQ   = 2'b11;
`ifdef AHB_SLV_TIMEOUT_EN
    localparam int          TMO  = 256;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata = '0;

    ahb_slave_bridge_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ahb_slave_bridge_v2 #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (BASE),
        .ADDR_SPACE    (SPACE),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .i_clk_ahb(clk),
        .i_rst_ahb(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign bus.i_hready = bus.o_hreadyout;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    function automatic bit addr_bad(input logic [31:0] a, input int size);
        if (a < BASE || a >= BASE + SPACE) return 1'b1;
        if (size > 2) return 1'b1;
        return (a % (32'd1 << size)) != 32'd0;
    endfunction

    function automatic logic [3:0] exp_strb(input bit wr, input int size, input logic [31:0] a);
        logic [31:0] m;
        if (!wr) return 4'hF;
        m = ((32'd1 << (32'd1 << size)) - 32'd1) << (a % 32'd4);
        return m[3:0];
    endfunction

    task automatic wait_slot(input string tag);
        for (int g = 0; g < 64 && !(bus.o_hreadyout && !bus.o_hresp); g++) @(negedge clk);
        check({tag, "_slot"}, 64'(bus.o_hreadyout && !bus.o_hresp), 64'(1));
    endtask

    // One AHB transfer; the bench also plays the backend with the given ready/response delays.
    task automatic xfer(input bit wr, input logic [1:0] trans, input int size, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int rdly, input int vdly,
                        input bit berr, input string tag);
        bit aerr, exp_err, done, hs_done, saw_err1;
        int waits, vcyc, since_hs, exp_waits, exp_vcyc;
        aerr      = addr_bad(a, size);
        exp_err   = aerr || berr;
        exp_waits = aerr ? 1 : (wr ? 2 + rdly : rdly + 1 + vdly);
        exp_vcyc  = aerr ? 0 : rdly + 1;
`ifdef AHB_SLV_TIMEOUT_EN
        if (!aerr && rdly >= TMO) begin
            exp_err   = 1'b1;
            exp_waits = (wr ? 1 : 0) + TMO + 1;
            exp_vcyc  = TMO;
        end
`endif
        wait_slot(tag);
        bus.i_hselx  = 1'b1;
        bus.i_htrans = trans;
        bus.i_hsize  = 3'(size);
        bus.i_hwrite = wr;
        bus.i_haddr  = a;
        @(negedge clk);
        bus.i_htrans = 2'b00;
        bus.i_hselx  = 1'($urandom % 2);
        bus.i_hwdata = wd;
        done = 0; hs_done = 0; saw_err1 = 0; waits = 0; vcyc = 0; since_hs = 0;
        for (int c = 0; c < 700 && !done; c++) begin
            bus.i_ready    = 1'b0;
            bus.i_rd_valid = 1'b0;
            bus.i_rd_err   = 1'b0;
            bus.i_rd_data  = $urandom;
            if (bus.o_hreadyout) begin
                done = 1;
            end else begin
                waits++;
                if (bus.o_hresp) saw_err1 = 1;
                if (bus.o_valid) begin
                    if (vcyc == 0) begin
                        check({tag, "_addr"}, 64'(bus.o_addr), 64'(a - BASE));
                        check({tag, "_dir"}, 64'(bus.o_rd0_wr1), 64'(wr));
                        check({tag, "_strb"}, 64'(bus.o_wstrb), 64'(exp_strb(wr, size, a)));
                        if (wr) check({tag, "_wdata"}, 64'(bus.o_wr_data), 64'(wd));
                    end
                    if (vcyc == rdly) begin
                        bus.i_ready = 1'b1;
                        hs_done     = 1;
                        if (wr) begin
                            bus.i_rd_err = berr;
                        end else if (vdly == 0) begin
                            bus.i_rd_valid = 1'b1;
                            bus.i_rd_data  = rd;
                            bus.i_rd_err   = berr;
                        end
                    end
                    vcyc++;
                end else if (hs_done && !wr) begin
                    since_hs++;
                    if (since_hs == vdly) begin
                        bus.i_rd_valid = 1'b1;
                        bus.i_rd_data  = rd;
                        bus.i_rd_err   = berr;
                    end
                end
                @(negedge clk);
            end
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        if (!done) begin
            finish_run();
            return;
        end
        check({tag, "_waits"}, 64'(waits), 64'(exp_waits));
        check({tag, "_vcyc"}, 64'(vcyc), 64'(exp_vcyc));
        check({tag, "_hresp"}, 64'(bus.o_hresp), 64'(exp_err));
        if (aerr) check({tag, "_err1"}, 64'(saw_err1), 64'(1));
        if (!wr && !exp_err) begin
            check({tag, "_rdata"}, 64'(bus.o_hrdata), 64'(rd));
            last_rdata = rd;
        end
    endtask

    // A cycle that must not start a transfer (not selected, BUSY or IDLE).
    task automatic idle_cycle(input bit sel, input logic [1:0] trans, input string tag);
        wait_slot(tag);
        bus.i_hselx  = sel;
        bus.i_htrans = trans;
        bus.i_hwrite = 1'($urandom % 2);
        bus.i_hsize  = 3'd2;
        bus.i_haddr  = BASE;
        @(negedge clk);
        bus.i_hselx  = 1'b0;
        bus.i_htrans = 2'b00;
        check({tag, "_rdy"}, 64'(bus.o_hreadyout), 64'(1));
        check({tag, "_vld"}, 64'(bus.o_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] junk;
        int          size;
        int          sel;
        rst            = 1'b1;
        bus.i_hselx    = 1'b0;
        bus.i_htrans   = 2'b00;
        bus.i_hsize    = 3'd0;
        bus.i_hwrite   = 1'b0;
        bus.i_haddr    = '0;
        bus.i_hwdata   = '0;
        bus.i_ready    = 1'b0;
        bus.i_rd_valid = 1'b0;
        bus.i_rd_data  = '0;
        bus.i_rd_err   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hreadyout", 64'(bus.o_hreadyout), 64'(1));
        check("rst_hresp", 64'(bus.o_hresp), 64'(0));
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_addr", 64'(bus.o_addr), 64'(0));
        check("rst_wstrb", 64'(bus.o_wstrb), 64'(0));
        check("rst_hrdata", 64'(bus.o_hrdata), 64'(0));
        check("rst_wr_data", 64'(bus.o_wr_data), 64'(0));
        check("rst_dir", 64'(bus.o_rd0_wr1), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        xfer(1, NS, 2, BASE + 32'h8, 32'hA5A5_1234, 32'h0, 0, 0, 0, "wr_word");
        xfer(0, NS, 2, BASE + 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, "rd_late");

        // Read response outside a read must not disturb HRDATA.
        junk = $urandom;
        bus.i_rd_valid = 1'b1;
        bus.i_rd_data  = junk ^ 32'h5555_AAAA;
        @(negedge clk);
        bus.i_rd_valid = 1'b0;
        check("stray_rdvalid", 64'(bus.o_hrdata), 64'(last_rdata));

        xfer(1, NS, 0, BASE + 32'h3, 32'h1122_3344, 32'h0, 1, 0, 0, "wr_byte3");
        xfer(1, NS, 1, BASE + 32'h1, 32'h0, 32'h0, 0, 0, 0, "wr_half_misalign");
        xfer(1, NS, 2, BASE + SPACE, 32'h0, 32'h0, 0, 0, 0, "wr_out_of_range");

        // Still in ERR2 here: a transfer offered now is dropped.
        bus.i_hselx  = 1'b1;
        bus.i_htrans = NS;
        bus.i_hwrite = 1'b1;
        bus.i_hsize  = 3'd2;
        bus.i_haddr  = BASE + 32'h10;
        @(negedge clk);
        bus.i_hselx  = 1'b0;
        bus.i_htrans = 2'b00;
        check("err2_ignore_rdy", 64'(bus.o_hreadyout), 64'(1));
        check("err2_ignore_resp", 64'(bus.o_hresp), 64'(0));
        check("err2_ignore_vld", 64'(bus.o_valid), 64'(0));

        xfer(0, NS, 2, BASE + 32'hFFC, 32'h0, $urandom, 2, 1, 0, "rd_after_err");

        for (int i = 0; i < 4; i++) begin
            xfer(0, (i == 0) ? NS : SQ, 2, BASE + 32'h40 + 32'(4 * i), 32'h0, $urandom, 0, 0, 0,
                 $sformatf("burst%0d", i));
        end

        xfer(1, NS, 2, BASE + 32'h20, $urandom, 32'h0, 1, 0, 1, "wr_backend_err");
        xfer(0, NS, 2, BASE + 32'h24, 32'h0, $urandom, 0, 2, 1, "rd_backend_err");
        xfer(1, NS, 3, BASE + 32'h28, 32'h0, 32'h0, 0, 0, 0, "wr_size3");
        xfer(0, NS, 2, BASE - 32'h4, 32'h0, 32'h0, 0, 0, 0, "rd_below_base");
`ifdef AHB_SLV_TIMEOUT_EN
        xfer(0, NS, 2, BASE + 32'h30, 32'h0, 32'h0, 100000, 0, 0, "rd_timeout");
`endif

        for (int n = 0; n < 150; n++) begin
            size = ($urandom % 10 == 0) ? 3 : int'($urandom % 3);
            a = BASE + ($urandom % SPACE);
            a = a - (a % (32'd1 << size));
            case ($urandom % 12)
                0: a = a | 32'h1;
                1: a = BASE + SPACE + 32'(4 * ($urandom % 64));
                2: a = BASE - 32'h4 - 32'(4 * ($urandom % 64));
                default: ;
            endcase
            if ($urandom % 4 == 0) begin
                sel = int'($urandom % 3);
                idle_cycle(sel != 0, (sel == 1) ? 2'b01 : (sel == 2) ? 2'b00 : NS, "gap");
            end
            xfer(1'($urandom % 2), ($urandom % 2) ? NS : SQ, size, a, $urandom, $urandom,
                 int'($urandom % 4), int'($urandom % 4), ($urandom % 8) == 0, $sformatf("rnd%0d", n));
        end

        // Asynchronous reset while waiting in RD_RESP.
        wait_slot("rst_mid");
        bus.i_hselx  = 1'b1;
        bus.i_htrans = NS;
        bus.i_hwrite = 1'b0;
        bus.i_hsize  = 3'd2;
        bus.i_haddr  = BASE + 32'h50;
        @(negedge clk);
        bus.i_hselx  = 1'b0;
        bus.i_htrans = 2'b00;
        bus.i_ready  = 1'b1;
        @(negedge clk);
        bus.i_ready  = 1'b0;
        check("rst_mid_pre_rdy", 64'(bus.o_hreadyout), 64'(0));
        rst = 1'b1;
        #1;
        check("rst_mid_rdy", 64'(bus.o_hreadyout), 64'(1));
        check("rst_mid_vld", 64'(bus.o_valid), 64'(0));
        check("rst_mid_resp", 64'(bus.o_hresp), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(0, NS, 2, BASE + 32'h54, 32'h0, $urandom, 1, 1, 0, "rd_after_rst");

        finish_run();
    end
endmodule
